rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters; legal range N >= 2.
REQ-002 SHALL have localparam IW = $clog2(N), width of the grant index.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  N  per-requester request level; bit i means requester i wants access.
REQ-006 SHALL have port req_last  input  1  the current beat is the final beat of the granted transfer.
REQ-007 SHALL have port grant_ready  input  1  the consumer accepts the current beat.
REQ-008 SHALL have port grant_valid  output  1  a grant is active.
REQ-009 SHALL have port grant  output  N  one-hot grant, all-zero when grant_valid=0.
REQ-010 SHALL have port grant_idx  output  IW  binary index of the granted requester, 0 when grant_valid=0.

Function
REQ-011 SHALL implement two states: ARB_IDLE and ARB_GRANT.
REQ-012 SHALL, in ARB_IDLE with req != 0, pick the winner as the first set req bit at or after ptr, wrapping modulo N, and enter ARB_GRANT, with outputs registered.
- grant_valid rises one cycle after req is sampled.
REQ-013 SHALL, in ARB_IDLE with req == 0, remain idle with grant_valid=0.
REQ-014 SHALL hold grant, grant_idx and grant_valid stable in ARB_GRANT until completion or abort.
REQ-015 SHALL treat a handshake as grant_valid && grant_ready; a handshake with req_last=0 keeps the grant.
REQ-016 SHALL, on completion (handshake with req_last=1):
- set ptr to (grant_idx+1) mod N;
- in the same cycle, re-pick from the current req using the new ptr;
- if a winner exists, stay in ARB_GRANT with the new winner (back-to-back, no bubble);
- otherwise return to ARB_IDLE.
REQ-017 SHALL abort when req[grant_idx] deasserts during ARB_GRANT without completion.
- Next cycle: grant_valid=0, ptr = (grant_idx+1) mod N, state ARB_IDLE.
- No re-pick in the abort cycle.
REQ-018 SHALL give completion priority when completion and deassertion of req[grant_idx] occur in the same cycle.
REQ-019 SHALL wrap the ptr increment from N-1 to 0.
- For non-power-of-two N, ptr SHALL never hold a value >= N.
REQ-020 SHALL let the granted requester win again after completion only if no other requester is pending, since rotation starts after it.
REQ-021 SHALL keep grant equal to the decode of grant_idx while grant_valid=1.

Reset
REQ-022 SHALL, while rst=1 and independent of clk, force:
- state ARB_IDLE, ptr=0;
- grant_valid=0, grant=0, grant_idx=0.
REQ-023 SHALL, on reset asserted mid-transfer, drop the grant immediately with no completion and no ptr advance.
REQ-024 SHALL evaluate requests starting from the first rising clk edge after rst deasserts.

Structure
REQ-025 SHALL place the state enum typedef (ARB_IDLE, ARB_GRANT) in shared package arb_pkg.
REQ-026 SHALL implement the rotating pick as combinational sub-module rr_pick.
- Inputs: req, ptr.
- Outputs: found, idx (binary), onehot.
- Instantiated once; rr_arbiter keeps only the state, ptr and output registers.

Verification
REQ-027 SHALL cover reset/first grant: N=4, rst then req=0001 at cycle 0 -> cycle 1: grant_valid=1, grant=0001, grant_idx=0.
REQ-028 SHALL cover rotation: req=1111 held, grant_ready=1, req_last=1 every cycle -> grant_idx 0,1,2,3,0,1 on consecutive cycles, no bubbles.
REQ-029 SHALL cover backpressure: grant on idx 2, grant_ready=0 for 5 cycles -> grant=0100 stable; then ready&last -> next grant goes to idx 3 if req[3]=1, else wraps to the lowest pending.
REQ-030 SHALL cover a multi-beat hold: req=0011, grant on idx 0, 3 handshakes with req_last=0 then 1 with req_last=1 -> idx 0 held for 4 beats, then idx 1.
REQ-031 SHALL cover abort: grant on idx 1, req[1] drops with no handshake -> next cycle grant_valid=0; then req=1111 -> grant_idx=2.
REQ-032 SHALL cover async reset: rst pulsed between clk edges during a grant on idx 3 -> grant_valid=0 and grant=0 immediately; after release, req=1111 -> grant_idx=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Holds the arbiter state encoding and the modulo-N index wrap used by the pick logic.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Adds an offset below n to a base below n and wraps without a divider.
    function automatic int wrapAdd(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority pick.
// Finds the first set request bit at or after ptr, wrapping modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    // Scan from the farthest offset down so the closest hit to ptr is written last.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrapAdd(int'(ptr), k, N)]) begin
                found = 1'b1;
                idx   = IW'(wrapAdd(int'(ptr), k, N));
            end
        end
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with multi-beat grants, abort on request drop,
// and back-to-back re-arbitration on transfer completion.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          req_last,
    input  logic          grant_ready,
    output logic          grant_valid,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    arb_state_t    r_state;
    logic [IW-1:0] r_ptr;
    logic          r_grant_valid;
    logic [N-1:0]  r_grant;
    logic [IW-1:0] r_grant_idx;

    logic          w_complete;
    logic          w_abort;
    logic [IW-1:0] w_next_ptr;
    logic [IW-1:0] w_pick_ptr;
    logic          w_found;
    logic [IW-1:0] w_pick_idx;
    logic [N-1:0]  w_pick_onehot;

    assign w_complete = r_grant_valid & grant_ready & req_last;
    assign w_abort    = ~req[r_grant_idx] & ~w_complete;
    assign w_next_ptr = (r_grant_idx == IW'(N - 1)) ? '0 : (r_grant_idx + IW'(1));

    // While granting, the only re-pick happens on completion, which rotates past the current owner.
    assign w_pick_ptr = (r_state == ARB_GRANT) ? w_next_ptr : r_ptr;

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (w_pick_ptr),
        .found  (w_found),
        .idx    (w_pick_idx),
        .onehot (w_pick_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ARB_IDLE;
            r_ptr         <= '0;
            r_grant_valid <= 1'b0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_state       <= ARB_GRANT;
                        r_grant_valid <= 1'b1;
                        r_grant       <= w_pick_onehot;
                        r_grant_idx   <= w_pick_idx;
                    end
                end
                ARB_GRANT: begin
                    if (w_complete) begin
                        r_ptr <= w_next_ptr;
                        if (w_found) begin
                            r_grant     <= w_pick_onehot;
                            r_grant_idx <= w_pick_idx;
                        end else begin
                            r_state       <= ARB_IDLE;
                            r_grant_valid <= 1'b0;
                            r_grant       <= '0;
                            r_grant_idx   <= '0;
                        end
                    end else if (w_abort) begin
                        r_ptr         <= w_next_ptr;
                        r_state       <= ARB_IDLE;
                        r_grant_valid <= 1'b0;
                        r_grant       <= '0;
                        r_grant_idx   <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed scoreboard bench for rr_arbiter (N=4): the driver queues the response
// each vector should produce and an independent monitor compares at the negedge.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       reqLast;
    logic       grantReady;
    logic       grantValid;
    logic [3:0] grant;
    logic [1:0] grantIdx;

    typedef struct {
        int         tgt;
        logic       v;
        logic [3:0] g;
        logic [1:0] i;
        string      name;
    } exp_t;

    exp_t sbq[$];
    event sbPoke;
    int   cyc = 0;
    int   vectorCount = 0;
    int   missCount = 0;

    rr_arbiter #(.N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_last    (reqLast),
        .grant_ready (grantReady),
        .grant_valid (grantValid),
        .grant       (grant),
        .grant_idx   (grantIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input exp_t e);
        vectorCount++;
        if (grantValid !== e.v || grant !== e.g || grantIdx !== e.i) begin
            missCount++;
            $display("[TB] FAIL %s: got valid=%b grant=%b idx=%0d, want valid=%b grant=%b idx=%0d",
                     e.name, grantValid, grant, grantIdx, e.v, e.g, e.i);
        end
    endtask

    // Drive one vector at posedge+1, queue the response expected after the next edge.
    task automatic applyStimulus(input logic [3:0] r, input logic l, input logic rdy,
                                 input logic ev, input logic [3:0] eg, input logic [1:0] ei,
                                 input string name);
        exp_t e;
        req        = r;
        reqLast    = l;
        grantReady = rdy;
        e.tgt = cyc + 1; e.v = ev; e.g = eg; e.i = ei; e.name = name;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation that must hold right now, without waiting for a clock edge.
    task automatic expectNow(input logic ev, input logic [3:0] eg, input logic [1:0] ei,
                             input string name);
        exp_t e;
        e.tgt = -1; e.v = ev; e.g = eg; e.i = ei; e.name = name;
        sbq.push_back(e);
        ->sbPoke;
    endtask

    // Monitor: consume every expectation whose cycle has arrived, independent of the driver.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sbPoke);
            while (sbq.size() > 0) begin
                if (sbq[0].tgt < 0 || sbq[0].tgt == cyc) begin
                    e = sbq.pop_front();
                    checkOutput(e);
                end else if (sbq[0].tgt < cyc) begin
                    e = sbq.pop_front();
                    vectorCount++;
                    missCount++;
                    $display("[TB] FAIL %s: check slot missed at cycle %0d, wanted cycle %0d",
                             e.name, cyc, e.tgt);
                end else begin
                    break;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        rst        = 1'b1;
        req        = 4'b0000;
        reqLast    = 1'b0;
        grantReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expectNow(1'b0, 4'b0000, 2'd0, "reset_state");
        rst = 1'b0;

        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, "first_grant");
        applyStimulus(4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, "sole_requester_rewins");

        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0010, 2'd1, "rotate_1");
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, "rotate_2");
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3, "rotate_3");
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, "rotate_wrap_0");
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0010, 2'd1, "rotate_1b");
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, "rotate_2b");

        for (int k = 0; k < 5; k++)
            applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, "backpressure_hold");
        applyStimulus(4'b0011, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, "complete_wins_over_drop_wrap");

        for (int k = 0; k < 3; k++)
            applyStimulus(4'b0011, 1'b0, 1'b1, 1'b1, 4'b0001, 2'd0, "multibeat_hold");
        applyStimulus(4'b0011, 1'b1, 1'b1, 1'b1, 4'b0010, 2'd1, "multibeat_done");

        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, "abort_drop");
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0100, 2'd2, "after_abort_idx2");
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, "complete_to_idle");
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, "idle_no_req");
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, 2'd3, "grant_idx3");

        // Pulse reset between edges after the idx3 grant has been checked.
        @(negedge clk);
        #1 rst = 1'b1;
        #1 expectNow(1'b0, 4'b0000, 2'd0, "async_reset_drop");
        #1 rst = 1'b0;
        req        = 4'b1111;
        reqLast    = 1'b0;
        grantReady = 1'b0;
        e.tgt = cyc + 1; e.v = 1'b1; e.g = 4'b0001; e.i = 2'd0; e.name = "post_reset_ptr0";
        sbq.push_back(e);
        @(posedge clk);
        #1;

        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0010, 2'd1, "post_reset_rotate");
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, "final_abort");

        repeat (3) @(posedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectorCount++;
            missCount++;
            $display("[TB] FAIL %s: expectation never checked, want valid=%b grant=%b idx=%0d",
                     e.name, e.v, e.g, e.i);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
